// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - multi-layer conv sequencer: weight load, compute, drain, ping-pong swap
module cnn_layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int ADDR_W     = 12,
    parameter int WADDR_W    = 14,
    parameter int LAYER_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               locked,
    input  logic               start,
    input  logic               abort,
    input  logic [WADDR_W-1:0] cfg_w_words,
    input  logic [ADDR_W-1:0]  cfg_in_words,
    input  logic [ADDR_W-1:0]  cfg_out_words,
    input  logic               pe_ready,
    input  logic               pe_out_valid,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               weight_en,
    output logic [WADDR_W-1:0] weight_addr,
    output logic               calc_en,
    output logic               rd_valid,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic               buf_sel,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    typedef enum logic [2:0] {IDLE, WLOAD, COMPUTE, DRAIN, SWAP, DONE} state_t;

    state_t             state, state_nxt;
    logic [WADDR_W-1:0] wbase, wcnt;
    logic [ADDR_W-1:0]  rcnt, ocnt;

    logic run_start, last_layer, out_full, in_empty, w_empty, ovf_hit;

    assign run_start   = start && locked;
    assign last_layer  = (layer_idx == LAYER_W'(NUM_LAYERS - 1));
    assign out_full    = (ocnt >= cfg_out_words);
    assign in_empty    = (cfg_in_words == '0);
    assign w_empty     = (cfg_w_words == '0);
    assign ovf_hit     = calc_en && pe_out_valid && out_full;

    assign weight_addr = wbase + wcnt;
    assign rd_addr     = rcnt;
    assign wr_addr     = ocnt;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        weight_en = 1'b0;
        calc_en   = 1'b0;
        rd_valid  = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (run_start) state_nxt = WLOAD;
            end
            WLOAD: begin
                weight_en = !w_empty;
                if (w_empty || wcnt == cfg_w_words - WADDR_W'(1)) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                calc_en  = 1'b1;
                rd_valid = pe_ready && !in_empty;
                wr_en    = pe_out_valid && !out_full;
                if (in_empty || (pe_ready && rcnt == cfg_in_words - ADDR_W'(1)))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                calc_en = 1'b1;
                wr_en   = pe_out_valid && !out_full;
                // Leave only once the count seen at cycle start is already complete.
                if (out_full) state_nxt = SWAP;
            end
            SWAP: begin
                state_nxt = last_layer ? DONE : WLOAD;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer_idx <= '0;
            wbase     <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
            ocnt      <= '0;
            buf_sel   <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_start) begin
                        layer_idx <= '0;
                        wbase     <= '0;
                        wcnt      <= '0;
                        rcnt      <= '0;
                        ocnt      <= '0;
                        buf_sel   <= 1'b0;
                        ovf       <= 1'b0;
                    end
                end
                WLOAD: begin
                    if (weight_en) wcnt <= wcnt + WADDR_W'(1);
                end
                COMPUTE, DRAIN: begin
                    if (rd_valid) rcnt <= rcnt + ADDR_W'(1);
                    if (wr_en)    ocnt <= ocnt + ADDR_W'(1);
                    if (ovf_hit)  ovf  <= 1'b1;
                end
                SWAP: begin
                    // An abort here keeps buf_sel pointing at the last completed layer.
                    if (!abort) begin
                        buf_sel <= !buf_sel;
                        wbase   <= wbase + cfg_w_words;
                        wcnt    <= '0;
                        rcnt    <= '0;
                        ocnt    <= '0;
                        if (!last_layer) layer_idx <= layer_idx + LAYER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - directed and randomized checks of cnn_layer_sequencer against a schedule model
module tb_cnn_layer_sequencer;
    localparam int NL   = 2;
    localparam int AW   = 12;
    localparam int WW   = 14;
    localparam int LW   = 2;
    localparam int MAXC = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          locked = 1'b0, start = 1'b0, abort = 1'b0;
    logic [WW-1:0] cfg_w_words;
    logic [AW-1:0] cfg_in_words, cfg_out_words;
    logic          pe_ready = 1'b0, pe_out_valid = 1'b0;
    logic [LW-1:0] layer_idx;
    logic          weight_en, calc_en, rd_valid, wr_en, buf_sel, busy, done, ovf;
    logic [WW-1:0] weight_addr;
    logic [AW-1:0] rd_addr, wr_addr;

    logic [WW-1:0] lw[4];
    logic [AW-1:0] lin[4], lout[4];

    assign cfg_w_words   = lw[layer_idx];
    assign cfg_in_words  = lin[layer_idx];
    assign cfg_out_words = lout[layer_idx];

    cnn_layer_sequencer #(.NUM_LAYERS(NL), .ADDR_W(AW), .WADDR_W(WW), .LAYER_W(LW)) dut (
        .clk(clk), .rst(rst), .locked(locked), .start(start), .abort(abort),
        .cfg_w_words(cfg_w_words), .cfg_in_words(cfg_in_words), .cfg_out_words(cfg_out_words),
        .pe_ready(pe_ready), .pe_out_valid(pe_out_valid), .layer_idx(layer_idx),
        .weight_en(weight_en), .weight_addr(weight_addr), .calc_en(calc_en),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .buf_sel(buf_sel), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit rdy[MAXC], vld[MAXC];
    bit e_wen[MAXC], e_calc[MAXC], e_rdv[MAXC], e_wr[MAXC], e_busy[MAXC], e_done[MAXC];
    bit e_buf[MAXC], e_ovf[MAXC];
    int e_waddr[MAXC], e_rdaddr[MAXC], e_wraddr[MAXC], e_layer[MAXC];
    int last_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks the layer schedule phase by phase and lays out what every cycle should show.
    task automatic build_model();
        int c = 0, ovf_cur = 0, bsel = 0, wbase = 0, oc, rc, w, nin, nout;
        bit stop;
        for (int i = 0; i < MAXC; i++) begin
            e_wen[i] = 0; e_calc[i] = 0; e_rdv[i] = 0; e_wr[i] = 0; e_busy[i] = 0;
            e_done[i] = 0; e_buf[i] = 0; e_ovf[i] = 0; e_waddr[i] = 0; e_rdaddr[i] = 0;
            e_wraddr[i] = 0; e_layer[i] = 0;
        end
        for (int l = 0; l < NL; l++) begin
            w = int'(lw[l]); nin = int'(lin[l]); nout = int'(lout[l]);
            for (int k = 0; k < ((w == 0) ? 1 : w); k++) begin
                e_busy[c] = 1; e_layer[c] = l; e_buf[c] = bsel[0]; e_ovf[c] = ovf_cur[0];
                if (w > 0) begin
                    e_wen[c] = 1;
                    e_waddr[c] = (wbase + k) % (1 << WW);
                end
                c++;
            end
            rc = 0; oc = 0;
            for (int ph = 0; ph < 2; ph++) begin
                stop = 0;
                while (!stop && c < MAXC - 4) begin
                    e_busy[c] = 1; e_layer[c] = l; e_buf[c] = bsel[0]; e_ovf[c] = ovf_cur[0];
                    e_calc[c] = 1;
                    if (ph == 0) begin
                        if (nin > 0 && rdy[c]) begin
                            e_rdv[c] = 1; e_rdaddr[c] = rc; rc++;
                        end
                        stop = (nin == 0) || (rc == nin);
                    end else begin
                        stop = (oc >= nout);
                    end
                    if (vld[c]) begin
                        if (oc < nout) begin
                            e_wr[c] = 1; e_wraddr[c] = oc; oc++;
                        end else begin
                            ovf_cur = 1;
                        end
                    end
                    c++;
                end
            end
            e_busy[c] = 1; e_layer[c] = l; e_buf[c] = bsel[0]; e_ovf[c] = ovf_cur[0];
            c++;
            bsel ^= 1;
            wbase += w;
        end
        e_busy[c] = 1; e_layer[c] = NL - 1; e_buf[c] = bsel[0]; e_ovf[c] = ovf_cur[0];
        e_done[c] = 1;
        c++;
        e_busy[c] = 0; e_layer[c] = NL - 1; e_buf[c] = bsel[0]; e_ovf[c] = ovf_cur[0];
        last_c = c;
    endtask

    task automatic run_trace(input string name, input bit hold_start);
        build_model();
        @(posedge clk); #1;
        locked = 1; start = 1; pe_ready = 0; pe_out_valid = 0;
        @(posedge clk);
        for (int c = 0; c <= last_c; c++) begin
            #1;
            start = hold_start && (c < last_c);
            pe_ready = rdy[c]; pe_out_valid = vld[c];
            @(negedge clk);
            chk($sformatf("%s c%0d weight_en", name, c), 32'(weight_en), 32'(e_wen[c]));
            chk($sformatf("%s c%0d calc_en", name, c), 32'(calc_en), 32'(e_calc[c]));
            chk($sformatf("%s c%0d rd_valid", name, c), 32'(rd_valid), 32'(e_rdv[c]));
            chk($sformatf("%s c%0d wr_en", name, c), 32'(wr_en), 32'(e_wr[c]));
            chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(e_busy[c]));
            chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(e_done[c]));
            chk($sformatf("%s c%0d buf_sel", name, c), 32'(buf_sel), 32'(e_buf[c]));
            chk($sformatf("%s c%0d ovf", name, c), 32'(ovf), 32'(e_ovf[c]));
            chk($sformatf("%s c%0d layer_idx", name, c), 32'(layer_idx), e_layer[c]);
            if (e_wen[c]) chk($sformatf("%s c%0d weight_addr", name, c), 32'(weight_addr), e_waddr[c]);
            if (e_rdv[c]) chk($sformatf("%s c%0d rd_addr", name, c), 32'(rd_addr), e_rdaddr[c]);
            if (e_wr[c])  chk($sformatf("%s c%0d wr_addr", name, c), 32'(wr_addr), e_wraddr[c]);
            @(posedge clk);
        end
        #1;
        start = 0; pe_ready = 0; pe_out_valid = 0;
    endtask

    task automatic set_cfg(input int w0, input int i0, input int o0, input int w1, input int i1, input int o1);
        lw[0] = WW'(w0); lin[0] = AW'(i0); lout[0] = AW'(o0);
        lw[1] = WW'(w1); lin[1] = AW'(i1); lout[1] = AW'(o1);
        lw[2] = '0; lin[2] = '0; lout[2] = '0;
        lw[3] = '0; lin[3] = '0; lout[3] = '0;
    endtask

    task automatic fill_vec(input int mode);
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0: begin rdy[c] = 1; vld[c] = 1; end
                1: begin rdy[c] = (c % 2 == 0); vld[c] = 1; end
                default: begin
                    rdy[c] = ($urandom_range(0, 1) == 1) || (c % 8 == 7);
                    vld[c] = ($urandom_range(0, 1) == 1) || (c % 8 == 3);
                end
            endcase
        end
    endtask

    task automatic check_quiet(input string name);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " done"}, 32'(done), 32'd0);
        chk({name, " weight_en"}, 32'(weight_en), 32'd0);
        chk({name, " calc_en"}, 32'(calc_en), 32'd0);
        chk({name, " rd_valid"}, 32'(rd_valid), 32'd0);
        chk({name, " wr_en"}, 32'(wr_en), 32'd0);
    endtask

    initial begin
        set_cfg(3, 4, 4, 3, 4, 4);
        #12;
        check_quiet("reset");
        chk("reset buf_sel", 32'(buf_sel), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        chk("reset layer_idx", 32'(layer_idx), 32'd0);
        chk("reset weight_addr", 32'(weight_addr), 32'd0);
        chk("reset rd_addr", 32'(rd_addr), 32'd0);
        chk("reset wr_addr", 32'(wr_addr), 32'd0);
        #3 rst = 1;

        fill_vec(0); run_trace("basic", 0);

        set_cfg(2, 4, 2, 2, 4, 2);
        fill_vec(1); run_trace("ready_toggle", 0);

        set_cfg(1, 4, 2, 2, 3, 2);
        fill_vec(0); run_trace("overflow", 0);

        set_cfg(0, 3, 2, 0, 2, 1);
        fill_vec(0); run_trace("zero_weights", 0);

        set_cfg(2, 3, 3, 1, 2, 2);
        fill_vec(2); run_trace("start_busy", 1);

        for (int r = 0; r < 6; r++) begin
            set_cfg($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 5));
            fill_vec(2);
            run_trace($sformatf("rand%0d", r), ($urandom_range(0, 1) == 1));
        end

        // Start without clock lock must be ignored.
        @(posedge clk); #1;
        locked = 0; start = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_quiet($sformatf("unlocked c%0d", c));
        end
        @(posedge clk); #1;
        start = 0; locked = 1;

        // Abort during layer 0 drain.
        set_cfg(1, 1, 3, 1, 1, 3);
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0; pe_ready = 1; pe_out_valid = 0;
        @(negedge clk);
        chk("abort wload weight_en", 32'(weight_en), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort compute rd_valid", 32'(rd_valid), 32'd1);
        @(posedge clk); #1;
        pe_ready = 0; abort = 1;
        @(negedge clk);
        chk("abort drain calc_en", 32'(calc_en), 32'd1);
        chk("abort drain busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        abort = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_quiet($sformatf("aborted c%0d", c));
            chk($sformatf("aborted c%0d buf_sel", c), 32'(buf_sel), 32'd0);
        end

        // Asynchronous reset in the middle of weight load.
        set_cfg(5, 2, 2, 5, 2, 2);
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid weight_addr before", 32'(weight_addr), 32'd1);
        #2 rst = 0;
        #1;
        check_quiet("rstmid");
        chk("rstmid weight_addr", 32'(weight_addr), 32'd0);
        chk("rstmid layer_idx", 32'(layer_idx), 32'd0);
        @(posedge clk); #3;
        rst = 1;

        set_cfg(3, 4, 4, 3, 4, 4);
        fill_vec(0); run_trace("after_reset", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_layer_sequencer.md
CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 Parameter NUM_LAYERS, 3: number of conv layers run per start.
REQ-002 Parameter ADDR_W, 12: feature-map BRAM address width.
REQ-003 Parameter WADDR_W, 14: weight ROM address width.
REQ-004 Parameter LAYER_W, 2: layer index width, SHALL satisfy 2^LAYER_W >= NUM_LAYERS.
REQ-005 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-006 Port rst  in  1  asynchronous, active-low reset.
REQ-007 Port locked  in  1  clock-wizard lock; start ignored while 0.
REQ-008 Port start  in  1  begin a run, sampled in IDLE only.
REQ-009 Port abort  in  1  synchronous run cancel.
REQ-010 Port cfg_w_words  in  WADDR_W  weight words for current layer.
REQ-011 Port cfg_in_words  in  ADDR_W  ifmap words to read for current layer.
REQ-012 Port cfg_out_words  in  ADDR_W  ofmap words expected for current layer.
REQ-013 Port pe_ready  in  1  PE accepts one ifmap word this cycle.
REQ-014 Port pe_out_valid  in  1  PE presents one ofmap word this cycle.
REQ-015 Port layer_idx  out  LAYER_W  current layer; drives external cfg lookup.
REQ-016 Port weight_en / weight_addr  out  1 / WADDR_W  weight ROM fetch strobe and address.
REQ-017 Port calc_en  out  1  PE compute enable.
REQ-018 Port rd_valid / rd_addr  out  1 / ADDR_W  ifmap read strobe and address.
REQ-019 Port wr_en / wr_addr  out  1 / ADDR_W  ofmap write strobe and address.
REQ-020 Port buf_sel  out  1  0: read buffer A, write buffer B; 1: reverse.
REQ-021 Port busy / done / ovf  out  1 each  run active / end-of-run pulse / sticky surplus-output flag.

Function
REQ-022 States SHALL be IDLE, WLOAD, COMPUTE, DRAIN, SWAP, DONE.
REQ-023 IDLE: start=1 and locked=1 -> WLOAD; layer_idx, wbase, all counters, buf_sel, ovf cleared to 0; start while busy SHALL be ignored.
REQ-024 WLOAD: weight_en=1, weight_addr=wbase+wcnt (modulo 2^WADDR_W), wcnt+1 per cycle; after cycle with wcnt=cfg_w_words-1 -> COMPUTE.
REQ-025 WLOAD with cfg_w_words=0: one cycle, weight_en=0, -> COMPUTE.
REQ-026 COMPUTE: calc_en=1; rd_valid=pe_ready (combinational); rd_addr=rcnt; rcnt+1 only when pe_ready=1; pe_ready=0 stalls rcnt.
REQ-027 COMPUTE -> DRAIN after the cycle with rcnt=cfg_in_words-1 and pe_ready=1; cfg_in_words=0 -> DRAIN immediately.
REQ-028 DRAIN: calc_en=1, rd_valid=0; -> SWAP in the cycle after ocnt reaches cfg_out_words.
REQ-029 In COMPUTE and DRAIN: pe_out_valid=1 and ocnt<cfg_out_words -> wr_en=1, wr_addr=ocnt, ocnt+1; ocnt>=cfg_out_words -> wr_en=0, ovf set (sticky).
REQ-030 Writes and reads SHALL proceed in the same cycle when both strobes are valid.
REQ-031 SWAP (one cycle): buf_sel toggles, wbase+=cfg_w_words, wcnt/rcnt/ocnt cleared; layer_idx=NUM_LAYERS-1 -> DONE, else layer_idx+1 and -> WLOAD.
REQ-032 DONE: done=1 exactly one cycle, -> IDLE; buf_sel retained to mark the buffer holding the final result.
REQ-033 busy=1 in every state except IDLE.
REQ-034 abort=1 in any non-IDLE state -> IDLE next edge; all strobes 0 that edge onward; done not pulsed; buf_sel, ovf retained.
REQ-035 abort and start together in IDLE: start wins.
REQ-036 Strobes (weight_en, calc_en, rd_valid, wr_en) SHALL be 0 outside their listed states.

Reset
REQ-037 rst=0 SHALL force IDLE immediately, independent of clk; all outputs and internal counters 0.
REQ-038 Reset mid-run SHALL abandon the run with no done pulse; first start after rst=1 begins from layer 0.

Verification
REQ-039 NUM_LAYERS=2, cfg_w=3, in=4, out=4, pe_ready=1, pe_out_valid=1 in COMPUTE -> weight_addr 0,1,2 then 3,4,5; rd_addr 0..3; wr_addr 0..3 per layer; buf_sel 0->1->0; done one cycle.
REQ-040 pe_ready toggled 1,0,1,0 in COMPUTE -> rd_addr advances only on ready cycles; rd_valid mirrors pe_ready; in=4 finishes after 4 ready cycles.
REQ-041 out=2 with 3 pe_out_valid pulses -> wr_addr 0,1; third pulse wr_en=0, ovf=1 until next start.
REQ-042 cfg_w_words=0 -> one WLOAD cycle, weight_en never 1, COMPUTE on next cycle.
REQ-043 abort in DRAIN of layer 0 -> IDLE next cycle, busy=0, no done; rst=0 mid-WLOAD -> outputs 0 asynchronously.
REQ-044 start with locked=0 -> stays IDLE, busy=0; start while busy -> no restart, counters undisturbed.
